// File: rtl/calc_tx_pkg.sv
// Shared types and frame-length helpers for the calculator serial transmitter.
// Defining CALC_TX_PARITY_EN appends one even-parity bit to every frame.
package calc_tx_pkg;

    typedef enum logic [1:0] {IDLE, LOADED, SHIFT, DONE} tx_state_t;

`ifdef CALC_TX_PARITY_EN
    localparam int PARITY_LEN = 1;
`else
    localparam int PARITY_LEN = 0;
`endif

    function automatic int frameLen(input int dataW, input logic fullWord);
        return (fullWord ? dataW : dataW / 2) + PARITY_LEN;
    endfunction

    // Counter must reach the longest frame (DATA_W + parity) without wrapping.
    function automatic int cntWidth(input int dataW);
        return $clog2(dataW + 2);
    endfunction

endpackage

// File: rtl/calc_tx_shifter.sv
// Load/shift register with bit counter; lastBitSent rises once the whole
// frame (including the optional parity bit) has been shifted out.
module calc_tx_shifter
    import calc_tx_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load,
    input  logic              shift,
    input  logic              mode,
    input  logic [DATA_W-1:0] dataIn,
    output logic              currentBit,
    output logic              lastBitSent
);

    localparam int HALF_W = DATA_W / 2;
    localparam int REG_W  = DATA_W + PARITY_LEN;
    localparam int CNT_W  = cntWidth(DATA_W);
    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(frameLen(DATA_W, 1'b1));
    localparam logic [CNT_W-1:0] HALF_LEN = CNT_W'(frameLen(DATA_W, 1'b0));

    logic [REG_W-1:0] shiftReg;
    logic [REG_W-1:0] loadWord;
    logic [CNT_W-1:0] bitCount;
    logic             modeReg;

`ifdef CALC_TX_PARITY_EN
    // Parity sits directly above the last data bit so it shifts out next.
    always_comb begin
        loadWord = '0;
        if (mode) begin
            loadWord = {^dataIn, dataIn};
        end else begin
            loadWord[HALF_W:0] = {^dataIn[HALF_W-1:0], dataIn[HALF_W-1:0]};
        end
    end
`else
    assign loadWord = dataIn;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            shiftReg <= '0;
            bitCount <= '0;
            modeReg  <= 1'b0;
        end else if (load) begin
            shiftReg <= loadWord;
            bitCount <= '0;
            modeReg  <= mode;
        end else if (shift) begin
            shiftReg <= shiftReg >> 1;
            bitCount <= bitCount + CNT_W'(1);
        end
    end

    assign currentBit  = shiftReg[0];
    assign lastBitSent = (bitCount == (modeReg ? FULL_LEN : HALF_LEN));

endmodule

// File: rtl/calc_serial_tx.sv
// Serial output stage for the calculator: captures a result word and shifts
// it out LSB first under control handshake. Optional parity: CALC_TX_PARITY_EN.
module calc_serial_tx
    import calc_tx_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              SampleData,
    input  logic              TransferData,
    input  logic              Mode,
    input  logic [DATA_W-1:0] DataIn,
    output logic              DataOut,
    output logic              OutValid,
    output logic              TransferDone,
    output logic              TxBusy
);

    tx_state_t stateReg;
    logic      loadWord;
    logic      shiftBit;
    logic      currentBit;
    logic      lastBitSent;

    // A sample in LOADED only counts while control is not yet transferring.
    assign loadWord = SampleData &&
                      ((stateReg == IDLE) || (stateReg == LOADED && !TransferData));
    assign shiftBit = TransferData &&
                      ((stateReg == LOADED) || (stateReg == SHIFT && !lastBitSent));

    calc_tx_shifter #(
        .DATA_W(DATA_W)
    ) shifterInst (
        .Clk        (Clk),
        .Reset      (Reset),
        .load       (loadWord),
        .shift      (shiftBit),
        .mode       (Mode),
        .dataIn     (DataIn),
        .currentBit (currentBit),
        .lastBitSent(lastBitSent)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stateReg     <= IDLE;
            DataOut      <= 1'b0;
            OutValid     <= 1'b0;
            TransferDone <= 1'b0;
            TxBusy       <= 1'b0;
        end else begin
            OutValid     <= 1'b0;
            TransferDone <= 1'b0;
            unique case (stateReg)
                IDLE: begin
                    if (SampleData) begin
                        stateReg <= LOADED;
                        TxBusy   <= 1'b1;
                    end
                end
                LOADED: begin
                    if (TransferData) begin
                        stateReg <= SHIFT;
                        DataOut  <= currentBit;
                        OutValid <= 1'b1;
                    end
                end
                SHIFT: begin
                    // Completion does not wait on TransferData; a pause holds DataOut.
                    if (lastBitSent) begin
                        stateReg     <= DONE;
                        TransferDone <= 1'b1;
                        TxBusy       <= 1'b0;
                    end else if (TransferData) begin
                        DataOut  <= currentBit;
                        OutValid <= 1'b1;
                    end
                end
                DONE: begin
                    stateReg <= IDLE;
                end
                default: begin
                    stateReg <= IDLE;
                    TxBusy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_serial_tx.sv
// Directed bench for calc_serial_tx: full/half frames, pause, post-done hold,
// async reset mid-frame, simultaneous sample/transfer and reload in LOADED.
module tb_calc_serial_tx;

    localparam int DATA_W = 16;
`ifdef CALC_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        SampleData;
    logic        TransferData;
    logic        Mode;
    logic [15:0] DataIn;
    logic        DataOut;
    logic        OutValid;
    logic        TransferDone;
    logic        TxBusy;

    int checkCount = 0;
    int errorCount = 0;

    always #5 Clk = ~Clk;

    calc_serial_tx #(
        .DATA_W(DATA_W)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .SampleData  (SampleData),
        .TransferData(TransferData),
        .Mode        (Mode),
        .DataIn      (DataIn),
        .DataOut     (DataOut),
        .OutValid    (OutValid),
        .TransferDone(TransferDone),
        .TxBusy      (TxBusy)
    );

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // expBits[i] is the i-th bit expected on the line; pauseAfter=0 means no pause.
    task automatic sendFrame(input string name, input logic mode, input logic [15:0] data,
                             input int expLen, input logic [16:0] expBits,
                             input int pauseAfter, input bit simul, input bit doPre);
        int idx = 0;
        int doneCycle = -1;
        int expDone;
        expDone = expLen + 1 + ((pauseAfter > 0) ? 3 : 0);
        if (doPre) begin
            SampleData = 1'b1; Mode = ~mode; DataIn = ~data; TransferData = 1'b0;
            tick;
        end
        SampleData = 1'b1; Mode = mode; DataIn = data; TransferData = simul;
        tick;
        checkValue({name, " loadOV"}, 32'(OutValid), 32'd0);
        SampleData = 1'b0; DataIn = 16'h0000; Mode = ~mode; TransferData = 1'b1;
        checkValue({name, " busy"}, 32'(TxBusy), 32'd1);
        for (int c = 1; c <= 40 && doneCycle < 0; c++) begin
            tick;
            if (OutValid) begin
                if (idx < expLen) checkValue({name, " bit"}, 32'(DataOut), 32'(expBits[idx]));
                idx++;
                if (idx == pauseAfter) begin
                    TransferData = 1'b0;
                    for (int p = 0; p < 3; p++) begin
                        tick;
                        c++;
                        checkValue({name, " pauseOV"}, 32'(OutValid), 32'd0);
                        checkValue({name, " pauseHold"}, 32'(DataOut), 32'(expBits[idx-1]));
                    end
                    TransferData = 1'b1;
                end
            end
            if (TransferDone) begin
                doneCycle = c;
                checkValue({name, " doneOV"}, 32'(OutValid), 32'd0);
                checkValue({name, " doneBusy"}, 32'(TxBusy), 32'd0);
            end
        end
        checkValue({name, " doneCycle"}, 32'(doneCycle), 32'(expDone));
        checkValue({name, " bitCount"}, 32'(idx), 32'(expLen));
        // TransferData lingers after completion; no new frame may start.
        for (int h = 0; h < 2; h++) begin
            tick;
            checkValue({name, " holdOV"}, 32'(OutValid), 32'd0);
            checkValue({name, " holdDone"}, 32'(TransferDone), 32'd0);
            checkValue({name, " holdBusy"}, 32'(TxBusy), 32'd0);
        end
        TransferData = 1'b0;
        tick;
        $display("frame %s: mode=%0b data=%h bits=%0d done at cycle %0d", name, mode, data, idx, doneCycle);
    endtask

    initial begin
        int seen;
        bit anyActivity;
        Reset = 1'b1; SampleData = 1'b0; TransferData = 1'b0; Mode = 1'b0; DataIn = '0;
        #12;
        checkValue("resetOutputs", 32'({DataOut, OutValid, TransferDone, TxBusy}), 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        tick;

        sendFrame("full", 1'b1, 16'hA5C3, 16 + PAR, 17'h0A5C3, 0, 1'b0, 1'b0);
        sendFrame("half", 1'b0, 16'hFF3C, 8 + PAR, 17'h0003C, 0, 1'b0, 1'b0);
        sendFrame("pause", 1'b1, 16'hA5C3, 16 + PAR, 17'h0A5C3, 5, 1'b0, 1'b0);

        // Async reset during bit 7 (a 1 on the line) clears everything at once.
        SampleData = 1'b1; Mode = 1'b1; DataIn = 16'hA5C3;
        tick;
        SampleData = 1'b0; TransferData = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && seen < 7; c++) begin
            tick;
            if (OutValid) seen++;
        end
        checkValue("rst bitsBefore", 32'(seen), 32'd7);
        checkValue("rst bit7", 32'(DataOut), 32'd1);
        #2 Reset = 1'b1;
        #1;
        checkValue("rst asyncClear", 32'({DataOut, OutValid, TransferDone, TxBusy}), 32'd0);
        tick;
        Reset = 1'b0;
        anyActivity = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick;
            if (OutValid || TransferDone || TxBusy) anyActivity = 1'b1;
        end
        checkValue("rst noResume", 32'(anyActivity), 32'd0);
        TransferData = 1'b0;
        tick;
        $display("reset mid-frame: bits before reset=%0d", seen);

        sendFrame("simul", 1'b0, 16'h0007, 8 + PAR, 17'h00107, 0, 1'b1, 1'b0);
        sendFrame("reload", 1'b0, 16'hFF3C, 8 + PAR, 17'h0003C, 0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
